// File: rtl/register_packet_controller_pkg.sv
// Shared definitions for the register packet controller.
// Contents:
//   state_t    - controller FSM state encoding
//   DEST_WRITE - DEST byte value selecting a register write packet
//   DEST_READ  - DEST byte value selecting a register read packet
//   sat_inc8   - saturating 8-bit increment used by the event counters
package register_packet_controller_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_DEST,
    GET_LENGTH,
    GET_ADDRESS,
    WR_DATA,
    SKIP,
    RD_HEADER,
    RD_REQUEST,
    RD_WAIT,
    RD_DATA
  } state_t;

  localparam logic [7:0] DEST_WRITE = 8'h00;
  localparam logic [7:0] DEST_READ  = 8'h01;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/register_packet_controller_byte_timeout_counter.sv
// Inter-byte idle timer.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   clear   - restart the idle count (a byte arrived)
//   enable  - count only while a packet is being received
//   expired - high for the cycle in which TIMEOUT_CLKS idle clocks have elapsed
module register_packet_controller_byte_timeout_counter #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // A clear in the same cycle as the terminal count wins: a byte that just
  // arrived means the line is not idle.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/register_packet_controller.sv
// Packet sequencer between the UART byte stream and the register file.
// Packet: SYNC, DEST, LEN, ADDR, payload. DEST 00 writes LEN bytes as
// little-endian 32-bit words; DEST 01 returns SYNC,01,LEN,ADDR followed by
// LEN bytes of read data. Any other DEST is skipped and counted as an error.
// Ports:
//   ipClk, ipReset           - clock, synchronous active-high reset
//   ipRxData/ipRxValid       - received byte strobe (no backpressure)
//   opTxData/opTxValid/ipTxReady - response byte stream; a byte moves when
//                              valid && ready; valid never drops and data
//                              never changes while a byte waits for ready
//   opAddress/opWrData       - register bus address and write data
//   opWrEnable/opRdEnable    - one-cycle register write/read strobes
//   ipRdData                 - read data, valid one clock after opRdEnable
//   opBusy                   - controller is inside a packet
//   opErrorCount             - saturating bad/timed-out packet count
//   opDropCount              - saturating count of rx bytes lost during reads
//   opState                  - current FSM state (debug)
module register_packet_controller
  import register_packet_controller_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'h55,
  parameter int         ADDR_WIDTH   = 8,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic [7:0]            ipRxData,
  input  logic                  ipRxValid,
  output logic [7:0]            opTxData,
  output logic                  opTxValid,
  input  logic                  ipTxReady,
  output logic [ADDR_WIDTH-1:0] opAddress,
  output logic [31:0]           opWrData,
  output logic                  opWrEnable,
  output logic                  opRdEnable,
  input  logic [31:0]           ipRdData,
  output logic                  opBusy,
  output logic [7:0]            opErrorCount,
  output logic [7:0]            opDropCount,
  output state_t                opState
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state;
  logic [7:0]            dest;
  logic [7:0]            len;
  logic [7:0]            addr_byte;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            byte_cnt;
  logic [1:0]            byte_idx;
  logic [1:0]            hdr_idx;
  logic [31:0]           word;
  logic [31:0]           rd_word;

  logic        expired;
  logic        timer_enable;
  logic        last_byte;
  logic        rd_phase;
  logic [31:0] next_word;
  logic [7:0]  next_rd_byte;

  assign opBusy  = (state != IDLE);
  assign opState = state;

  assign timer_enable = (state == GET_DEST) || (state == GET_LENGTH) ||
                        (state == GET_ADDRESS) || (state == WR_DATA) ||
                        (state == SKIP);
  assign rd_phase = (state == RD_HEADER) || (state == RD_REQUEST) ||
                    (state == RD_WAIT) || (state == RD_DATA);
  assign last_byte = (byte_cnt + 8'd1 == len);

  register_packet_controller_byte_timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (ipClk),
    .reset  (ipReset),
    .clear  (ipRxValid),
    .enable (timer_enable),
    .expired(expired)
  );

  // Word under assembly with the incoming byte merged in. Starting a new
  // word clears the upper lanes, so a short final word is zero-filled.
  always_comb begin
    next_word = word;
    case (byte_idx)
      2'd0:    next_word = {24'h0, ipRxData};
      2'd1:    next_word[15:8]  = ipRxData;
      2'd2:    next_word[23:16] = ipRxData;
      default: next_word[31:24] = ipRxData;
    endcase
  end

  // Byte of the captured read word that follows the one being sent.
  always_comb begin
    next_rd_byte = rd_word[7:0];
    case (byte_idx)
      2'd0:    next_rd_byte = rd_word[15:8];
      2'd1:    next_rd_byte = rd_word[23:16];
      default: next_rd_byte = rd_word[31:24];
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state        <= IDLE;
      dest         <= '0;
      len          <= '0;
      addr_byte    <= '0;
      addr         <= '0;
      byte_cnt     <= '0;
      byte_idx     <= '0;
      hdr_idx      <= '0;
      word         <= '0;
      rd_word      <= '0;
      opTxData     <= '0;
      opTxValid    <= 1'b0;
      opAddress    <= '0;
      opWrData     <= '0;
      opWrEnable   <= 1'b0;
      opRdEnable   <= 1'b0;
      opErrorCount <= '0;
      opDropCount  <= '0;
    end else begin
      opWrEnable <= 1'b0;
      opRdEnable <= 1'b0;

      if (rd_phase && ipRxValid) begin
        opDropCount <= sat_inc8(opDropCount);
      end

      case (state)
        IDLE: begin
          if (ipRxValid && ipRxData == SYNC_BYTE) begin
            state <= GET_DEST;
          end
        end

        GET_DEST: begin
          if (expired) begin
            state        <= IDLE;
            opErrorCount <= sat_inc8(opErrorCount);
          end else if (ipRxValid) begin
            dest  <= ipRxData;
            state <= GET_LENGTH;
          end
        end

        GET_LENGTH: begin
          if (expired) begin
            state        <= IDLE;
            opErrorCount <= sat_inc8(opErrorCount);
          end else if (ipRxValid) begin
            len      <= ipRxData;
            byte_cnt <= '0;
            byte_idx <= '0;
            hdr_idx  <= '0;
            state    <= GET_ADDRESS;
          end
        end

        GET_ADDRESS: begin
          if (expired) begin
            state        <= IDLE;
            opErrorCount <= sat_inc8(opErrorCount);
          end else if (ipRxValid) begin
            addr_byte <= ipRxData;
            addr      <= ADDR_WIDTH'(ipRxData);
            if (dest == DEST_WRITE) begin
              state <= (len == 8'd0) ? IDLE : WR_DATA;
            end else if (dest == DEST_READ) begin
              opTxValid <= 1'b1;
              opTxData  <= SYNC_BYTE;
              state     <= RD_HEADER;
            end else begin
              opErrorCount <= sat_inc8(opErrorCount);
              state        <= (len == 8'd0) ? IDLE : SKIP;
            end
          end
        end

        WR_DATA: begin
          if (expired) begin
            state        <= IDLE;
            opErrorCount <= sat_inc8(opErrorCount);
          end else if (ipRxValid) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + 8'd1;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3 || last_byte) begin
              opWrEnable <= 1'b1;
              opAddress  <= addr;
              opWrData   <= next_word;
              addr       <= addr + ADDR_ONE;
            end
            if (last_byte) begin
              state <= IDLE;
            end
          end
        end

        SKIP: begin
          if (expired) begin
            state        <= IDLE;
            opErrorCount <= sat_inc8(opErrorCount);
          end else if (ipRxValid) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (last_byte) begin
              state <= IDLE;
            end
          end
        end

        RD_HEADER: begin
          if (ipTxReady) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0:    opTxData <= DEST_READ;
              2'd1:    opTxData <= len;
              2'd2:    opTxData <= addr_byte;
              default: begin
                opTxValid <= 1'b0;
                state     <= (len == 8'd0) ? IDLE : RD_REQUEST;
              end
            endcase
          end
        end

        RD_REQUEST: begin
          opRdEnable <= 1'b1;
          opAddress  <= addr;
          state      <= RD_WAIT;
        end

        // First RD_WAIT cycle is the strobe cycle itself; the data arrives
        // on the following cycle, when the strobe has already dropped.
        RD_WAIT: begin
          if (!opRdEnable) begin
            rd_word   <= ipRdData;
            opTxData  <= ipRdData[7:0];
            opTxValid <= 1'b1;
            byte_idx  <= '0;
            state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (ipTxReady) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (last_byte) begin
              opTxValid <= 1'b0;
              state     <= IDLE;
            end else if (byte_idx == 2'd3) begin
              opTxValid <= 1'b0;
              addr      <= addr + ADDR_ONE;
              state     <= RD_REQUEST;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              opTxData <= next_rd_byte;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/register_packet_controller.md
Name: register_packet_controller

Overview:
Sequences the register-file datapath from the UART byte stream. Parses incoming packets into 32-bit register writes or reads. For reads, it streams the response packet back toward the UART transmitter with a valid/ready handshake. It sits between the UART receiver/transmitter and the register file, and is the sole master of the register bus.

Parameters:
SYNC_BYTE, 8'h55, first byte of every packet (rx and tx)
ADDR_WIDTH, 8, register word-address width
TIMEOUT_CLKS, 50000, idle clocks tolerated between bytes inside a packet

Ports:
ipClk  in  1  system clock
ipReset  in  1  synchronous, active-high reset
ipRxData  in  8  received byte
ipRxValid  in  1  one-cycle strobe, ipRxData valid; no backpressure
opTxData  out  8  response byte
opTxValid  out  1  response byte valid
ipTxReady  in  1  transmitter accepts byte when opTxValid && ipTxReady
opAddress  out  ADDR_WIDTH  register word address
opWrData  out  32  register write data
opWrEnable  out  1  one-cycle write strobe
opRdEnable  out  1  one-cycle read strobe
ipRdData  in  32  read data, valid exactly 1 clock after opRdEnable
opBusy  out  1  high whenever state != IDLE
opErrorCount  out  8  saturating count of bad/timed-out packets
opDropCount  out  8  saturating count of rx bytes discarded during tx

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet or mid-transmission aborts immediately; no further strobes.
- Packet format, bytes in order: SYNC, DEST, LEN, ADDR, then payload. DEST 8'h00 means write, 8'h01 means read. LEN is the byte count (0..255).
- IDLE: accept a byte only when it equals SYNC_BYTE, then go to GET_DEST. Other bytes are ignored silently.
- GET_DEST → GET_LENGTH → GET_ADDRESS: each state latches one byte.
- After ADDR is latched:
  - DEST=00, LEN>0 → WR_DATA.
  - DEST=00, LEN=0 → IDLE.
  - DEST=01 → RD_HEADER.
  - Any other DEST → SKIP, and opErrorCount increments.
- WR_DATA:
  - Bytes assemble little-endian (first byte = bits 7:0).
  - On the 4th byte of a word: opWrEnable pulses the next cycle with opAddress and opWrData. The address then increments, wrapping 2^ADDR_WIDTH-1 → 0.
  - When the final byte (LEN reached) completes a partial word: write it with the upper bytes zero-filled, then go to IDLE.
- SKIP: consume LEN bytes, then go to IDLE.
- RD_HEADER: transmit SYNC, 8'h01, LEN, ADDR. opTxValid stays asserted until each byte is accepted; opTxData is held stable while not accepted.
- RD_REQUEST: pulse opRdEnable. In RD_WAIT, capture ipRdData.
- RD_DATA:
  - Transmit the captured word LSB first, stopping after LEN bytes total.
  - A full word sent with bytes remaining → increment address, go to RD_REQUEST.
  - LEN=0 → header only.
  - Read address wraps the same way as writes.
- During RD_* states, every ipRxValid byte is dropped and opDropCount increments (saturating at 255).
- Timeout: in GET_* / WR_DATA / SKIP, a counter resets on every ipRxValid. On reaching TIMEOUT_CLKS: go to IDLE, opErrorCount++, discard any partial word.
- Tx states have no timeout; backpressure is unbounded.
- Counters saturate at 8'hFF.
- A SYNC byte appearing inside a payload is treated as data, with no resync.

Decomposition:
- Shared package: state enum (IDLE, GET_DEST, GET_LENGTH, GET_ADDRESS, WR_DATA, SKIP, RD_HEADER, RD_REQUEST, RD_WAIT, RD_DATA), DEST_WRITE=8'h00, DEST_READ=8'h01.
- One sub-module, byte_timeout_counter: inputs clear/enable, output expired.
- Everything else stays in one FSM.

Test Plan:
- Write: 55 00 04 10 EF BE AD DE → single opWrEnable, opAddress=8'h10, opWrData=32'hDEADBEEF; opBusy returns to 0.
- Partial write wrap: 55 00 06 FF 01 02 03 04 05 06 → writes (FF, 32'h04030201), then (00, 32'h00000605).
- Read with backpressure:
  - Stimulus: 55 01 05 20; ipRdData=32'h44332211 at 20, 32'h000000AA at 21; ipTxReady toggles every other cycle.
  - Response: tx 55 01 05 20 11 22 33 44 AA.
  - Exactly two opRdEnable pulses; opTxData is stable while stalled.
- Bad dest: 55 07 02 00 AB CD, then valid write → no strobes for the first packet, opErrorCount=1; second packet executes.
- Timeout: 55 00 04 10 01 02, then silence for TIMEOUT_CLKS → IDLE, no write, opErrorCount=1. A subsequent full packet works.
- Drop and reset: 3 rx bytes injected during read response → opDropCount=3. ipReset asserted mid-response → opTxValid=0 the next cycle, counters 0.
